// File: rtl/cdc_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_event_scheduler_pkg
// Purpose  : Shared state enumeration and default parameter constants for
//            the CDC event scheduler and its round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cdc_event_scheduler_pkg;

  localparam int unsigned C_N_REQ_DEFAULT          = 4;
  localparam int unsigned C_DATA_W_DEFAULT         = 8;
  localparam int unsigned C_TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

endpackage : cdc_event_scheduler_pkg
`default_nettype wire

// File: rtl/cdc_event_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin selector. The search starts at
//            last_i+1 and wraps, so the most recent winner has lowest priority.
// Ports    : req_i   - request vector
//            last_i  - index of the previous winner
//            gnt_o   - one-hot grant
//            idx_o   - binary index of the winner
//            valid_o - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import cdc_event_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = C_N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     valid_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = '0;
    // Offsets 1..N_REQ visit every requester once, ending on last_i itself.
    for (int k = 1; k <= int'(N_REQ); k++) begin
      w_cand = IDX_W'((int'(last_i) + k) % int'(N_REQ));
      if (!valid_o && req_i[w_cand]) begin
        valid_o = 1'b1;
        idx_o   = w_cand;
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdc_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cdc_event_scheduler
// Purpose  : Collects one-cycle event requests from N_REQ sources, buffers one
//            payload per source, and forwards them one at a time over a
//            toggle-handshake CDC channel using round-robin arbitration.
// Ports    : i_clk, i_rst (async, active high)
//            i_req/i_data        - per-requester event + payload
//            i_ack_toggle        - synchronized return toggle
//            i_clr_err           - clears overflow flags, resyncs from ERR
//            o_req_toggle/o_data/o_src_id - in-flight event
//            o_pending/o_overflow - per-requester status
//            o_done/o_busy/o_err  - transaction status
// Config   : define CDC_EVENT_SCHEDULER_TIMEOUT_EN to add the ack timeout
//            counter and the ERR recovery path.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_event_scheduler
  import cdc_event_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ          = C_N_REQ_DEFAULT,
  parameter int unsigned DATA_W         = C_DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  input  logic                      i_ack_toggle,
  input  logic                      i_clr_err,
  output logic                      o_req_toggle,
  output logic [DATA_W-1:0]         o_data,
  output logic [$clog2(N_REQ)-1:0]  o_src_id,
  output logic [N_REQ-1:0]          o_pending,
  output logic [N_REQ-1:0]          o_overflow,
  output logic                      o_done,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   overflow_q, overflow_d;
  logic [DATA_W-1:0]  buf_q [N_REQ];
  logic               toggle_q, toggle_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               done_q, done_d;

  logic [N_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic [N_REQ-1:0]   w_clr_mask;
  logic [N_REQ-1:0]   w_accept;
  logic               w_timeout;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (pending_q),
    .last_i  (last_q),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_valid)
  );

  // A request is accepted when its slot is free, or when the slot is being
  // granted this very edge (the new request replaces the outgoing one).
  assign w_accept   = i_req & (~pending_q | w_clr_mask);
  assign pending_d  = (pending_q & ~w_clr_mask) | i_req;
  assign overflow_d = i_clr_err ? '0 : (overflow_q | (i_req & ~w_accept));

  always_comb begin
    state_d    = state_q;
    toggle_d   = toggle_q;
    data_d     = data_q;
    src_d      = src_q;
    last_d     = last_q;
    done_d     = 1'b0;
    w_clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_valid) begin
          toggle_d   = ~toggle_q;
          data_d     = buf_q[w_idx];
          src_d      = w_idx;
          last_d     = w_idx;
          w_clr_mask = w_gnt;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (i_ack_toggle == toggle_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (w_timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        // A late ack closes the transaction silently; otherwise a clear
        // realigns our toggle with the far side so the channel is usable.
        if (i_ack_toggle == toggle_q) begin
          state_d = ST_IDLE;
        end else if (i_clr_err) begin
          toggle_d = i_ack_toggle;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      overflow_q <= '0;
      toggle_q   <= 1'b0;
      data_q     <= '0;
      src_q      <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      toggle_q   <= toggle_d;
      data_q     <= data_d;
      src_q      <= src_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  generate
    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_buf
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          buf_q[gi] <= '0;
        end else if (w_accept[gi]) begin
          buf_q[gi] <= i_data[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

`ifdef CDC_EVENT_SCHEDULER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts WAIT_ACK cycles; restarts from zero on every fresh grant.
  assign cnt_d     = (state_q == ST_WAIT_ACK) ? (cnt_q + 1'b1) : '0;
  assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_err     = (state_q == ST_ERR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
  wire w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign o_req_toggle = toggle_q;
  assign o_data       = data_q;
  assign o_src_id     = src_q;
  assign o_pending    = pending_q;
  assign o_overflow   = overflow_q;
  assign o_done       = done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule : cdc_event_scheduler
`default_nettype wire
